// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if
//   Bundles the EX-side inputs and the EX/MEM and MEM/WB outputs of the MEM/WB
//   stage pair. The stage uses the slave view. The EX stage, or a testbench,
//   uses the master view.
//   EX side (master -> slave):
//     flush, ex_ir, ex_aluout, ex_rd2, ex_wr, ex_regwrite, ex_memtoreg, ex_memwrite
//   Pipeline side (slave -> master):
//     exmem_ir, exmem_aluout, exmem_wr, exmem_regwrite,
//     memwb_ir, wb_wr, wb_wd, wb_regwrite
interface mem_wb_stage_if;
  logic        flush;
  logic [15:0] ex_ir;
  logic [15:0] ex_aluout;
  logic [15:0] ex_rd2;
  logic [1:0]  ex_wr;
  logic        ex_regwrite;
  logic        ex_memtoreg;
  logic        ex_memwrite;

  logic [15:0] exmem_ir;
  logic [15:0] exmem_aluout;
  logic [1:0]  exmem_wr;
  logic        exmem_regwrite;
  logic [15:0] memwb_ir;
  logic [1:0]  wb_wr;
  logic [15:0] wb_wd;
  logic        wb_regwrite;

  modport master (
    output flush, ex_ir, ex_aluout, ex_rd2, ex_wr, ex_regwrite, ex_memtoreg, ex_memwrite,
    input  exmem_ir, exmem_aluout, exmem_wr, exmem_regwrite,
           memwb_ir, wb_wr, wb_wd, wb_regwrite
  );

  modport slave (
    input  flush, ex_ir, ex_aluout, ex_rd2, ex_wr, ex_regwrite, ex_memtoreg, ex_memwrite,
    output exmem_ir, exmem_aluout, exmem_wr, exmem_regwrite,
           memwb_ir, wb_wr, wb_wd, wb_regwrite
  );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage
//   MEM and WB stages of the 16-bit pipelined CPU. Holds the EX/MEM and MEM/WB
//   pipeline registers and a word-addressed data memory. It executes lw/sw and
//   selects the write-back data for the register file. All state changes on the
//   falling clock edge, so the register file can write during clk-high.
//   Ports:
//     clk    pipeline clock (falling-edge active)
//     reset  asynchronous, active-high; clears both pipeline registers only
//     bus    mem_wb_stage_if.slave: EX inputs, forwarding info, write-back outputs
//   Parameters:
//     DEPTH  data memory words (power of 2)
//     AW     log2(DEPTH); the word index is byte address [AW:1]
module mem_wb_stage #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          reset,
  mem_wb_stage_if.slave bus
);

  // EX/MEM pipeline register
  logic [15:0] exmem_ir;
  logic [15:0] exmem_aluout;
  logic [15:0] exmem_rd2;
  logic [1:0]  exmem_wr;
  logic        exmem_regwrite;
  logic        exmem_memtoreg;
  logic        exmem_memwrite;

  // MEM/WB pipeline register
  logic [15:0] memwb_ir;
  logic [15:0] memwb_aluout;
  logic [15:0] memwb_rdata;
  logic [1:0]  memwb_wr;
  logic        memwb_regwrite;
  logic        memwb_memtoreg;

  logic [15:0] dmem [DEPTH];
  logic [AW-1:0] idx;
  logic [15:0] mem_rdata;

  // Bit 0 is the byte within a halfword. Bits above AW are dropped, so byte
  // addresses wrap modulo 2*DEPTH.
  assign idx       = exmem_aluout[AW:1];
  assign mem_rdata = dmem[idx];

  // A flushed instruction becomes a nop: it has no write-back and no store.
  // Only the fields that cause side effects are cleared.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      exmem_ir       <= '0;
      exmem_aluout   <= '0;
      exmem_rd2      <= '0;
      exmem_wr       <= '0;
      exmem_regwrite <= 1'b0;
      exmem_memtoreg <= 1'b0;
      exmem_memwrite <= 1'b0;
    end else begin
      exmem_aluout <= bus.ex_aluout;
      exmem_rd2    <= bus.ex_rd2;
      exmem_wr     <= bus.ex_wr;
      if (bus.flush) begin
        exmem_ir       <= '0;
        exmem_regwrite <= 1'b0;
        exmem_memtoreg <= 1'b0;
        exmem_memwrite <= 1'b0;
      end else begin
        exmem_ir       <= bus.ex_ir;
        exmem_regwrite <= bus.ex_regwrite;
        exmem_memtoreg <= bus.ex_memtoreg;
        exmem_memwrite <= bus.ex_memwrite;
      end
    end
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      memwb_ir       <= '0;
      memwb_aluout   <= '0;
      memwb_rdata    <= '0;
      memwb_wr       <= '0;
      memwb_regwrite <= 1'b0;
      memwb_memtoreg <= 1'b0;
    end else begin
      memwb_ir       <= exmem_ir;
      memwb_aluout   <= exmem_aluout;
      memwb_rdata    <= mem_rdata;
      memwb_wr       <= exmem_wr;
      memwb_regwrite <= exmem_regwrite;
      memwb_memtoreg <= exmem_memtoreg;
    end
  end

  // Memory contents survive reset. Reset clears exmem_memwrite asynchronously,
  // so a store still waiting in EX/MEM is dropped. A store commits on the same
  // edge that moves the next instruction into EX/MEM. A following lw to the
  // same word therefore reads the new value.
  always_ff @(negedge clk) begin
    if (exmem_memwrite) begin
      dmem[idx] <= exmem_rd2;
    end
  end

  assign bus.exmem_ir       = exmem_ir;
  assign bus.exmem_aluout   = exmem_aluout;
  assign bus.exmem_wr       = exmem_wr;
  assign bus.exmem_regwrite = exmem_regwrite;
  assign bus.memwb_ir       = memwb_ir;
  assign bus.wb_wr          = memwb_wr;
  assign bus.wb_regwrite    = memwb_regwrite;
  assign bus.wb_wd          = memwb_memtoreg ? memwb_rdata : memwb_aluout;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage
//   Directed testbench for mem_wb_stage. Inputs change 1 time unit after each
//   falling edge. Outputs are sampled at that same point, away from the active edge.
module tb_mem_wb_stage;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mem_wb_stage_if bus ();

  mem_wb_stage #(.DEPTH(1024), .AW(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", tag, actual, expected);
    end
  endtask

  // Drives one instruction into EX and lets the next falling edge capture it.
  task automatic applyStimulus(input logic [15:0] ir, input logic [15:0] aluout,
                               input logic [15:0] rd2, input logic [1:0] wr,
                               input logic regwrite, input logic memtoreg,
                               input logic memwrite, input logic fl);
    bus.ex_ir       = ir;
    bus.ex_aluout   = aluout;
    bus.ex_rd2      = rd2;
    bus.ex_wr       = wr;
    bus.ex_regwrite = regwrite;
    bus.ex_memtoreg = memtoreg;
    bus.ex_memwrite = memwrite;
    bus.flush       = fl;
    @(negedge clk);
    #1;
  endtask

  task automatic doStore(input logic [15:0] addr, input logic [15:0] data, input logic fl);
    applyStimulus(16'hB000, addr, data, 2'd0, 1'b0, 1'b0, 1'b1, fl);
  endtask

  task automatic doLoad(input logic [15:0] addr, input logic [1:0] wr);
    applyStimulus(16'h8000, addr, 16'h0000, wr, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic doNop();
    applyStimulus(16'h0000, 16'h0000, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_exmem_ir"}, bus.exmem_ir, 16'h0);
    checkOutput({tag, "_exmem_aluout"}, bus.exmem_aluout, 16'h0);
    checkOutput({tag, "_exmem_wr"}, {14'd0, bus.exmem_wr}, 16'h0);
    checkOutput({tag, "_exmem_regwrite"}, {15'd0, bus.exmem_regwrite}, 16'h0);
    checkOutput({tag, "_memwb_ir"}, bus.memwb_ir, 16'h0);
    checkOutput({tag, "_wb_wr"}, {14'd0, bus.wb_wr}, 16'h0);
    checkOutput({tag, "_wb_wd"}, bus.wb_wd, 16'h0);
    checkOutput({tag, "_wb_regwrite"}, {15'd0, bus.wb_regwrite}, 16'h0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bus.flush = 1'b0;
    bus.ex_ir = '0; bus.ex_aluout = '0; bus.ex_rd2 = '0; bus.ex_wr = '0;
    bus.ex_regwrite = 1'b0; bus.ex_memtoreg = 1'b0; bus.ex_memwrite = 1'b0;

    // Power-on reset.
    #1 reset = 1'b1;
    #1 checkAllZero("por");
    @(negedge clk);
    #1 reset = 1'b0;

    // ALU result reaches write-back two falling edges after presentation.
    applyStimulus(16'h2316, 16'd22, 16'h0000, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("alu_exmem_aluout", bus.exmem_aluout, 16'd22);
    checkOutput("alu_exmem_wr", {14'd0, bus.exmem_wr}, 16'd3);
    checkOutput("alu_exmem_regwrite", {15'd0, bus.exmem_regwrite}, 16'd1);
    checkOutput("alu_wb_early", {15'd0, bus.wb_regwrite}, 16'd0);
    doNop();
    checkOutput("alu_wb_wd", bus.wb_wd, 16'd22);
    checkOutput("alu_wb_wr", {14'd0, bus.wb_wr}, 16'd3);
    checkOutput("alu_wb_regwrite", {15'd0, bus.wb_regwrite}, 16'd1);
    checkOutput("alu_memwb_ir", bus.memwb_ir, 16'h2316);

    // A store followed immediately by a load of the same address.
    doStore(16'h0004, 16'h1234, 1'b0);
    doLoad(16'h0004, 2'd2);
    checkOutput("sw_wb_regwrite", {15'd0, bus.wb_regwrite}, 16'd0);
    checkOutput("sw_wb_wr", {14'd0, bus.wb_wr}, 16'd0);
    doNop();
    checkOutput("swlw_wb_wd", bus.wb_wd, 16'h1234);
    checkOutput("swlw_wb_wr", {14'd0, bus.wb_wr}, 16'd2);
    checkOutput("swlw_wb_regwrite", {15'd0, bus.wb_regwrite}, 16'd1);

    // A flushed store must not reach memory.
    doStore(16'h0006, 16'h0007, 1'b0);
    doStore(16'h0006, 16'hBEEF, 1'b1);
    checkOutput("flush_exmem_ir", bus.exmem_ir, 16'h0000);
    checkOutput("flush_exmem_regwrite", {15'd0, bus.exmem_regwrite}, 16'd0);
    doLoad(16'h0006, 2'd1);
    doNop();
    checkOutput("flush_lw_wd", bus.wb_wd, 16'h0007);

    // Addresses wrap modulo 2*DEPTH bytes.
    doStore(16'h0802, 16'h00AA, 1'b0);
    doLoad(16'h0002, 2'd1);
    doNop();
    checkOutput("wrap_lw_wd", bus.wb_wd, 16'h00AA);

    // Address bit 0 is ignored.
    doStore(16'h0005, 16'h1111, 1'b0);
    doLoad(16'h0004, 2'd3);
    doNop();
    checkOutput("bit0_lw_wd", bus.wb_wd, 16'h1111);
    checkOutput("bit0_lw_wr", {14'd0, bus.wb_wr}, 16'd3);

    // Back-to-back stores to the same address: the second one wins.
    doStore(16'h0008, 16'h0001, 1'b0);
    doStore(16'h0008, 16'h0002, 1'b0);
    doLoad(16'h0008, 2'd1);
    doNop();
    checkOutput("b2b_lw_wd", bus.wb_wd, 16'h0002);

    // Reset in mid-run while a store sits in EX/MEM.
    applyStimulus(16'h2155, 16'h0055, 16'h0000, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    doStore(16'h0004, 16'h9999, 1'b0);
    checkOutput("pre_rst_wb_wd", bus.wb_wd, 16'h0055);
    #1 reset = 1'b1;
    #1 checkAllZero("midrst");
    bus.ex_memwrite = 1'b0;
    bus.ex_regwrite = 1'b0;
    @(negedge clk);
    #1 reset = 1'b0;
    applyStimulus(16'h1033, 16'h0033, 16'h0000, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_wb_early", {15'd0, bus.wb_regwrite}, 16'd0);
    doNop();
    checkOutput("post_rst_wb_wd", bus.wb_wd, 16'h0033);
    checkOutput("post_rst_memwb_ir", bus.memwb_ir, 16'h1033);
    doLoad(16'h0004, 2'd2);
    doNop();
    checkOutput("rst_discard_store", bus.wb_wd, 16'h1111);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
